// File: rtl/serial_link.sv
// serial_link: 8N1 UART command link. RX bytes drive a small command parser
// that writes `control` ('W' + operand) or starts a TX reply: a snapshot of
// `data` LSB-first ('R') or the fixed ID byte ('?').
// Ports:
//   clk, reset (async, active high)
//   data           word snapshotted by the read command
//   rx / tx        serial in / out, both idle high
//   control        control register, control_strobe pulses on each write
//   frame_error    one-cycle pulse on a bad stop bit
//   busy           high while a reply is on the wire
module serial_link #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         DATA_BYTES   = 4,
    parameter logic [7:0] CTRL_RESET   = 8'h00,
    parameter logic [7:0] ID_BYTE      = 8'hA5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    rx,
    output logic                    tx,
    output logic [7:0]              control,
    output logic                    control_strobe,
    output logic                    frame_error,
    output logic                    busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BYTES + 1);
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_ID    = 8'h3F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

    typedef enum logic {
        P_CMD,
        P_OPERAND
    } parse_state_t;

    // ------------------------------------------------------------------
    // RX synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    uart_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = S_START;
            end
            S_START: begin
                // Mid-start-bit re-check rejects short glitches.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_valid_d = rx_sync_q;
                    ferr_d     = !rx_sync_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command parser
    // ------------------------------------------------------------------
    parse_state_t par_q, par_d;
    logic [7:0]   control_q, control_d;
    logic         strobe_q, strobe_d;
    logic         busy_q, busy_d;
    logic         start_rd;
    logic         start_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q     <= P_CMD;
            control_q <= CTRL_RESET;
            strobe_q  <= 1'b0;
        end else begin
            par_q     <= par_d;
            control_q <= control_d;
            strobe_q  <= strobe_d;
        end
    end

    always_comb begin
        par_d     = par_q;
        control_d = control_q;
        strobe_d  = 1'b0;
        start_rd  = 1'b0;
        start_id  = 1'b0;
        if (rx_valid_q) begin
            if (par_q == P_OPERAND) begin
                control_d = rx_shift_q;
                strobe_d  = 1'b1;
                par_d     = P_CMD;
            end else begin
                unique case (1'b1)
                    (rx_shift_q == CMD_READ):  start_rd = !busy_q;
                    (rx_shift_q == CMD_WRITE): par_d = P_OPERAND;
                    (rx_shift_q == CMD_ID):    start_id = !busy_q;
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    uart_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [DW-1:0] snap_q, snap_d;
    logic [DW-1:0] snap_nx;
    logic [BW-1:0] left_q, left_d;
    logic          tx_q, tx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            snap_q     <= '0;
            left_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            snap_q     <= snap_d;
            left_q     <= left_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        snap_d     = snap_q;
        snap_nx    = snap_q >> 8;
        left_d     = left_q;
        tx_d       = tx_q;
        unique case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                tx_d     = 1'b1;
                if (start_rd) begin
                    snap_d     = data;
                    tx_shift_d = data[7:0];
                    left_d     = BW'(DATA_BYTES);
                    tx_state_d = S_START;
                    tx_d       = 1'b0;
                end else if (start_id) begin
                    snap_d      = '0;
                    snap_d[7:0] = ID_BYTE;
                    tx_shift_d  = ID_BYTE;
                    left_d      = BW'(1);
                    tx_state_d  = S_START;
                    tx_d        = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    left_d   = left_q - BW'(1);
                    if (left_q == BW'(1)) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_IDLE;
                    end else begin
                        // Next byte starts with no idle gap.
                        snap_d     = snap_nx;
                        tx_shift_d = snap_nx[7:0];
                        tx_d       = 1'b0;
                        tx_state_d = S_START;
                    end
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign busy_d = (tx_state_d != S_IDLE);

    assign tx             = tx_q;
    assign control        = control_q;
    assign control_strobe = strobe_q;
    assign frame_error    = ferr_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_serial_link.sv
// tb_serial_link: directed plus randomized command traffic on rx, with a
// behavioural model predicting control writes, error pulses and tx replies.
module tb_serial_link;

    localparam int CPB = 16;
    localparam int DB  = 4;
    localparam int FR  = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        rx;
    logic        tx;
    logic [7:0]  control;
    logic        control_strobe;
    logic        frame_error;
    logic        busy;

    always #5 clk = ~clk;

    serial_link #(
        .CLKS_PER_BIT(CPB),
        .DATA_BYTES  (DB),
        .CTRL_RESET  (8'h00),
        .ID_BYTE     (8'hA5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data          (data),
        .rx            (rx),
        .tx            (tx),
        .control       (control),
        .control_strobe(control_strobe),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // observed pulse/level statistics
    int   st_cnt = 0, st_cyc = -1;
    int   fe_cnt = 0, fe_cyc = -1;
    int   busy_hi = 0, busy_rise = -1;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (control_strobe === 1'b1) begin
            st_cnt <= st_cnt + 1;
            st_cyc <= cyc;
        end
        if (frame_error === 1'b1) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (busy === 1'b1) begin
            busy_hi <= busy_hi + 1;
            if (busy_prev !== 1'b1) busy_rise <= cyc;
        end
        busy_prev <= busy;
    end

    // tx line decoder: samples each bit at its middle
    logic [7:0] mon_b[$];
    int         mon_st[$];
    bit         mon_ok[$];

    initial begin
        logic [7:0] b;
        int st;
        bit ok;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                b  = '0;
                repeat (CPB / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                mon_b.push_back(b);
                mon_st.push_back(st);
                mon_ok.push_back(ok);
            end
        end
    end

    // reference model state
    logic [7:0] m_ctrl = 8'h00;
    bit         m_op = 1'b0;
    int         m_busy_until = 0;
    logic [7:0] e_b[$];
    int         e_st[$];
    int         e_st_cnt = 0, e_st_cyc = -1;
    int         e_fe_cnt = 0, e_fe_cyc = -1;
    int         e_busy_hi = 0, e_busy_rise = -1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame starting at cycle k has its stop bit sampled at S = k+154
    // (2 sync + half bit + 9 bits); results land at S+1 / S+2.
    task automatic model(input logic [7:0] b, input bit ok, input int k,
                         input logic [31:0] d);
        int s1;
        int n;
        s1 = k + 2 + CPB / 2 + 9 * CPB + 1;
        if (!ok) begin
            e_fe_cnt++;
            e_fe_cyc = s1;
        end else if (m_op) begin
            m_ctrl   = b;
            m_op     = 1'b0;
            e_st_cnt++;
            e_st_cyc = s1 + 1;
        end else if (b == 8'h57) begin
            m_op = 1'b1;
        end else if ((b == 8'h52 || b == 8'h3F) && s1 >= m_busy_until) begin
            n = (b == 8'h52) ? DB : 1;
            for (int i = 0; i < n; i++) begin
                e_b.push_back((b == 8'h52) ? d[8*i +: 8] : 8'hA5);
                e_st.push_back(s1 + 1 + FR * i);
            end
            m_busy_until = s1 + 1 + FR * n;
            e_busy_hi   += FR * n;
            e_busy_rise  = s1 + 1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit ok);
        int k;
        logic [31:0] d;
        logic [9:0] fr;
        k  = cyc;
        d  = data;
        fr = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            tick(CPB);
        end
        rx = 1'b1;
        model(b, ok, k, d);
        chk("control", control, m_ctrl);
        chk("strobe_cnt", st_cnt, e_st_cnt);
        chk("strobe_cyc", st_cyc, e_st_cyc);
        chk("ferr_cnt", fe_cnt, e_fe_cnt);
        chk("ferr_cyc", fe_cyc, e_fe_cyc);
        if (!ok) tick(20);
    endtask

    task automatic drain_and_check();
        int n;
        n = m_busy_until + 20 - cyc;
        if (n > 0) tick(n);
        tick(CPB);
        chk("tx_count", mon_b.size(), e_b.size());
        while (mon_b.size() > 0 && e_b.size() > 0) begin
            chk("tx_byte", mon_b.pop_front(), e_b.pop_front());
            chk("tx_start", mon_st.pop_front(), e_st.pop_front());
            chk("tx_frame", mon_ok.pop_front(), 1'b1);
        end
        mon_b.delete();
        mon_st.delete();
        mon_ok.delete();
        e_b.delete();
        e_st.delete();
        chk("busy_cycles", busy_hi, e_busy_hi);
        chk("busy_rise", busy_rise, e_busy_rise);
        chk("busy_idle", busy, 1'b0);
        chk("tx_idle", tx, 1'b1);
    endtask

    initial begin
        int bad;
        int r;
        logic [7:0] b;

        reset = 1'b1;
        rx    = 1'b1;
        data  = '0;
        tick(3);
        chk("rst_tx", tx, 1'b1);
        chk("rst_control", control, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", control_strobe, 1'b0);
        chk("rst_ferr", frame_error, 1'b0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (tx !== 1'b1 || busy !== 1'b0 || control !== 8'h00) bad++;
        end
        chk("idle_hold", bad, 0);

        // read reply, data change mid-reply, write and '?' during TX
        data = 32'h1234ABCD;
        send(8'h52, 1'b1);
        data = 32'hDEADBEEF;
        send(8'h57, 1'b1);
        send(8'h07, 1'b1);
        send(8'h3F, 1'b1);
        drain_and_check();

        // write with operand equal to the read command
        send(8'h57, 1'b1);
        send(8'h52, 1'b1);
        drain_and_check();

        // ID reply, back-to-back read ignored while busy
        send(8'h3F, 1'b1);
        send(8'h52, 1'b1);
        drain_and_check();

        // framing error while waiting for operand
        send(8'h57, 1'b1);
        send(8'h5A, 1'b0);
        send(8'h3C, 1'b1);
        chk("ferr_ctrl", control, 8'h3C);

        // short glitch on rx
        rx = 1'b0;
        tick(CPB / 2 - 3);
        rx = 1'b1;
        tick(100);
        chk("glitch_ferr", fe_cnt, e_fe_cnt);
        chk("glitch_strobe", st_cnt, e_st_cnt);
        send(8'h57, 1'b1);
        send(8'h99, 1'b1);
        drain_and_check();

        // randomized traffic
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: begin
                    data = $urandom;
                    send(8'h52, 1'b1);
                end
                1: send(8'h3F, 1'b1);
                2: begin
                    send(8'h57, 1'b1);
                    send(8'($urandom), 1'b1);
                end
                3: begin
                    b = 8'($urandom);
                    if (b == 8'h52 || b == 8'h57 || b == 8'h3F) b = 8'h00;
                    send(b, 1'b1);
                end
                4: send(8'($urandom), 1'b0);
                default: tick($urandom_range(0, 200));
            endcase
        end
        if (m_op) send(8'h00, 1'b1);
        drain_and_check();

        // reset in the middle of a reply
        data = $urandom;
        send(8'h52, 1'b1);
        tick(300);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        tick(1);
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_control", control, 8'h00);
        reset = 1'b0;
        tick(5);
        chk("postrst_tx", tx, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_link.md
# serial_link

Parametrised full-duplex UART command link between the host USB-serial bridge and the oscilloscope core. It receives 8N1 command bytes on `rx` and updates the capture control register. On request it transmits a snapshot of a multi-byte status/data word on `tx`, or a fixed ID byte. Baud rate, data word width and control reset value are set by parameters.

## Interface
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit; must be >= 4.
- `DATA_BYTES`, 4: bytes in the `data` word, range 1..16.
- `CTRL_RESET`, 8'h00: value of `control` after reset.
- `ID_BYTE`, 8'hA5: byte returned by the ID command.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `data` in 8*DATA_BYTES: word sampled for the read command.
- `rx` in 1: serial input, asynchronous, idle high.
- `tx` out 1: serial output, idle high.
- `control` out 8: control register value.
- `control_strobe` out 1: one-cycle pulse when `control` is written.
- `frame_error` out 1: one-cycle pulse on a bad stop bit.
- `busy` out 1: high while a reply is being transmitted.

## Operation
- Reset values: `tx`=1, `control`=CTRL_RESET, `control_strobe`=0, `frame_error`=0, `busy`=0. All FSMs return to IDLE and all counters clear.
- Asserting reset mid-frame aborts immediately; `tx` is high on the next cycle with no partial stop bit.

**RX path**
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START when the synchronized `rx` is 0.
- In START, the FSM waits CLKS_PER_BIT/2 cycles (integer division), then re-samples. If the sample is 1, it is a glitch and the FSM returns to IDLE. If 0, it goes to DATA.
- DATA samples 8 bits, LSB first, one sample every CLKS_PER_BIT cycles.
- STOP samples once, CLKS_PER_BIT cycles after the last data sample. Stop=1 gives a one-cycle internal `rx_valid` with the byte. Stop=0 pulses `frame_error`, discards the byte and leaves the parser state unchanged. Both cases return to IDLE.

**Command parser**
- Parser states: CMD, OPERAND.
- In CMD, on `rx_valid`:
  - 0x52 'R': if not `busy`, latch all of `data` into a snapshot register and start a reply of DATA_BYTES bytes, least-significant byte first. If `busy`, ignore the byte.
  - 0x57 'W': go to OPERAND.
  - 0x3F '?': if not `busy`, start a 1-byte reply of ID_BYTE; otherwise ignore.
  - Any other byte: ignore and stay in CMD.
- In OPERAND, the next `rx_valid` byte is written to `control`, `control_strobe` pulses, and the parser returns to CMD.
  - The operand may be any value, including 0x52, 0x57 or 0x3F.
  - A framing error while in OPERAND keeps the parser waiting for the operand.
- Control writes are accepted while a reply is transmitting. RX and TX operate independently.

**TX path**
- TX FSM states: IDLE, START, DATA, STOP.
- Each bit lasts exactly CLKS_PER_BIT cycles: start bit 0, 8 data bits LSB first, stop bit 1.
- Consecutive reply bytes are back-to-back: the next start bit follows the previous stop bit with no idle gap.
- `busy` rises when a reply starts and falls in the cycle after the last stop bit completes.
- The snapshot register is not affected by `data` changing during a reply.

## Timing
- `rx` falling edge at the pin reaches the synchronized signal 2 cycles later.
- Let S be the cycle the stop bit is sampled:
  - `rx_valid` (internal) is asserted in cycle S+1.
  - `control` update and `control_strobe` are visible in cycle S+2.
  - `frame_error` is asserted in cycle S+1.
  - For 'R' and '?', the snapshot is taken from `data` in cycle S+1. `busy` and `tx`=0 (start bit) begin in cycle S+2.
- A reply of N bytes occupies exactly 10*N*CLKS_PER_BIT cycles of `tx` activity.
- Minimum accepted RX inter-byte gap: 0 (back-to-back frames). The RX FSM is back in IDLE by S+1.
- Bit counter width: clog2(CLKS_PER_BIT). Byte counter width: clog2(DATA_BYTES+1).

## Test plan
- Reset, then idle: `tx`=1, `control`=CTRL_RESET, `busy`=0 held for 1000 cycles. Pulse reset mid-reply: `tx`=1 and `busy`=0 on the next cycle.
- CLKS_PER_BIT=16, DATA_BYTES=4, `data`=32'h1234ABCD, send 'R':
  - `tx` emits CD, AB, 34, 12 back-to-back, each bit 16 cycles.
  - `busy` is high for 640 cycles.
  - Changing `data` mid-reply does not alter the output.
- Send 'W' then 0x52:
  - `control`=8'h52 at S+2 with a 1-cycle `control_strobe`.
  - No reply is started.
- Send '?' and, while its reply is in flight, send 'R':
  - Only ID_BYTE (A5) is transmitted.
  - The 'R' is ignored.
  - A subsequent 'W' 0x07 during TX still updates `control` to 07.
- Send a frame with stop bit 0 while in OPERAND, then a valid 0x3C:
  - `frame_error` pulses once.
  - `control`=3C afterwards.
- Drive a 0 glitch on `rx` shorter than CLKS_PER_BIT/2 cycles: no byte, no `frame_error`, RX returns to IDLE.
